// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// word layout and opcode encodings.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALTED
  } state_e;

  // Field order fixes the bit positions: opcode[31:24], rd[23:16], ra[15:8], rb[7:0].
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] rd;
    logic [7:0] ra;
    logic [7:0] rb;
  } instr_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_ADDI = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_BEQ  = 8'h11;
  localparam logic [7:0] OP_BNE  = 8'h12;
  localparam logic [7:0] OP_BLT  = 8'h13;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  function automatic logic is_write(input logic [7:0] op);
    return (op >= OP_LDI) && (op <= OP_ADDI);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of the sequencer's control, instruction-ROM and register-file signals.
// master = the sequencer, slave = the ROM / register file / controller side.
interface instr_sequencer_if;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [7:0]  src0;
  logic [7:0]  src1;
  logic [7:0]  dst;
  logic        we;
  logic [7:0]  data;
  logic [7:0]  outa;
  logic [7:0]  outb;
  logic        busy;
  logic        done;
  logic [15:0] icount;

  modport master (
    input  start, imem_data, outa, outb,
    output imem_addr, src0, src1, dst, we, data, busy, done, icount
  );

  modport slave (
    output start, imem_data, outa, outb,
    input  imem_addr, src0, src1, dst, we, data, busy, done, icount
  );
endinterface

// File: rtl/seq_alu.sv
// Combinational result mux / adder and branch-condition evaluation.
// All arithmetic wraps modulo 256.
module seq_alu
  import instr_sequencer_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] result,
  output logic       taken
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    taken  = 1'b0;
    case (op)
      OP_LDI:          result = imm;
      OP_MOV:          result = a;
      OP_ADD:          result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_ADDI:         result = a + imm;
      OP_JMP:          taken  = 1'b1;
      OP_BEQ:          taken  = (a == b);
      OP_BNE:          taken  = (a != b);
      OP_BLT:          taken  = (a < b);
      OP_NOP, OP_HLT:  result = '0;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Three-cycle FETCH/LATCH/EXEC instruction sequencer driving an external
// synchronous instruction ROM and an external register file.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [7:0] START_PC = 8'd0
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.master bus
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  instr_t      ir_q, ir_d;
  logic [15:0] icount_q, icount_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  alu_result;
  logic        alu_taken;
  logic        we_c;

  seq_alu u_alu (
    .op     (ir_q.opcode),
    .a      (bus.outa),
    .b      (bus.outb),
    .imm    (ir_q.rb),
    .result (alu_result),
    .taken  (alu_taken)
  );

  // Register-file reads depend on ir, so the write must be combinational in EXEC;
  // gating with rst kills a write that coincides with a reset.
  assign we_c = (state_q == S_EXEC) && is_write(ir_q.opcode) && !rst;

  assign bus.imem_addr = pc_q;
  assign bus.src0      = ir_q.ra;
  assign bus.src1      = ir_q.rb;
  assign bus.dst       = ir_q.rd;
  assign bus.we        = we_c;
  assign bus.data      = we_c ? alu_result : 8'd0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.icount    = icount_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d  = S_FETCH;
          pc_d     = START_PC;
          icount_d = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = instr_t'(bus.imem_data);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
        if (ir_q.opcode == OP_HLT) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_FETCH;
          pc_d    = alu_taken ? ir_q.rb : pc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d inside {S_FETCH, S_LATCH, S_EXEC};
    done_d = (state_d == S_HALTED);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ir_q     <= '0;
      icount_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: models the ROM and register file,
// predicts the fetch-address trace and every register write.
module tb_instr_sequencer;

  localparam logic [7:0] T_NOP  = 8'h00, T_LDI = 8'h01, T_MOV = 8'h02, T_ADD = 8'h03;
  localparam logic [7:0] T_SUB  = 8'h04, T_AND = 8'h05, T_OR  = 8'h06, T_XOR = 8'h07;
  localparam logic [7:0] T_ADDI = 8'h08, T_JMP = 8'h10, T_BEQ = 8'h11, T_BNE = 8'h12;
  localparam logic [7:0] T_BLT  = 8'h13, T_HLT = 8'hFF, T_UND = 8'h55;

  logic clk;
  logic rst;
  instr_sequencer_if bus();

  instr_sequencer #(.START_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rom  [256];
  logic [7:0]  regs [256];

  logic [7:0]  exp_fetch [$];
  logic [15:0] exp_wr    [$];

  int n_checks = 0;
  int n_errors = 0;
  int phase    = 0;
  bit was_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous ROM and register file with combinational reads.
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
  always @(posedge clk) if (bus.we) regs[bus.dst] <= bus.data;
  assign bus.outa = regs[bus.src0];
  assign bus.outb = regs[bus.src1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] ra, input logic [7:0] rb);
    return {op, rd, ra, rb};
  endfunction

  // Phase 0/1/2 tracks the expected FETCH/LATCH/EXEC rhythm while busy.
  always @(negedge clk) begin
    if (bus.busy) phase = (!was_busy || phase == 2) ? 0 : phase + 1;
    was_busy = bus.busy;
    if (bus.busy && phase == 0) begin
      if (exp_fetch.size() == 0) check("fetch_extra", {24'd0, bus.imem_addr}, 32'hFFFF_FFFF);
      else check("fetch_addr", {24'd0, bus.imem_addr}, {24'd0, exp_fetch.pop_front()});
    end
    if (bus.we) begin
      check("we_phase", 32'(phase), 32'd2);
      if (exp_wr.size() == 0) check("wr_extra", {16'd0, bus.dst, bus.data}, 32'hFFFF_FFFF);
      else check("wr_dst_data", {16'd0, bus.dst, bus.data}, {16'd0, exp_wr.pop_front()});
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = ins(T_HLT, 8'd0, 8'd0, 8'd0);
      regs[i] = 8'd0;
    end
  endtask

  task automatic emit(input logic [7:0] addr, input logic [31:0] word);
    rom[addr] = word;
    exp_fetch.push_back(addr);
  endtask

  task automatic exp_w(input logic [7:0] d, input logic [7:0] v);
    exp_wr.push_back({d, v});
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_reached", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_fetch_left"}, exp_fetch.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_addr",   {24'd0, bus.imem_addr}, 32'h00);
    check("rst_we",     {31'd0, bus.we}, 32'd0);
    check("rst_data",   {24'd0, bus.data}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_done",   {31'd0, bus.done}, 32'd0);
    check("rst_icount", {16'd0, bus.icount}, 32'd0);
    check("rst_ir",     {8'd0, bus.dst, bus.src0, bus.src1}, 32'd0);
    rst = 1'b0;

    // LDI r5,0x2A; HLT: write on 3rd cycle, done after 6 cycles.
    clear_mem();
    emit(8'h00, ins(T_LDI, 8'd5, 8'd0, 8'h2A));
    emit(8'h01, ins(T_HLT, 8'd0, 8'd0, 8'd0));
    exp_w(8'd5, 8'h2A);
    pulse_start();
    check("t1_busy_c1", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(negedge clk);
    check("t1_we_c3", {31'd0, bus.we}, 32'd1);
    repeat (3) @(negedge clk);
    check("t1_done_c6", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("t1_done_c7", {31'd0, bus.done}, 32'd1);
    check("t1_busy_c7", {31'd0, bus.busy}, 32'd0);
    check("t1_icount", {16'd0, bus.icount}, 32'd2);
    queues_empty("t1");

    // ALU ops with wrap, self-referencing write, MOV of a fresh result.
    clear_mem();
    emit(8'h00, ins(T_LDI,  8'd1,  8'd0, 8'hF0));
    emit(8'h01, ins(T_LDI,  8'd2,  8'd0, 8'h20));
    emit(8'h02, ins(T_ADD,  8'd3,  8'd1, 8'd2));
    emit(8'h03, ins(T_SUB,  8'd4,  8'd2, 8'd1));
    emit(8'h04, ins(T_AND,  8'd6,  8'd1, 8'd2));
    emit(8'h05, ins(T_OR,   8'd7,  8'd1, 8'd2));
    emit(8'h06, ins(T_XOR,  8'd8,  8'd1, 8'd2));
    emit(8'h07, ins(T_MOV,  8'd9,  8'd3, 8'd0));
    emit(8'h08, ins(T_ADDI, 8'd10, 8'd1, 8'h20));
    emit(8'h09, ins(T_ADDI, 8'd1,  8'd1, 8'h01));
    emit(8'h0A, ins(T_MOV,  8'd11, 8'd1, 8'd0));
    emit(8'h0B, ins(T_HLT,  8'd0,  8'd0, 8'd0));
    exp_w(8'd1, 8'hF0); exp_w(8'd2, 8'h20); exp_w(8'd3, 8'h10); exp_w(8'd4, 8'h30);
    exp_w(8'd6, 8'h20); exp_w(8'd7, 8'hF0); exp_w(8'd8, 8'hD0); exp_w(8'd9, 8'h10);
    exp_w(8'd10, 8'h10); exp_w(8'd1, 8'hF1); exp_w(8'd11, 8'hF1);
    pulse_start();
    wait_done(100);
    check("t2_icount", {16'd0, bus.icount}, 32'd12);
    queues_empty("t2");

    // Branches: rb field is both the compare register index and the target.
    clear_mem();
    emit(8'h00, ins(T_LDI, 8'd1,   8'd0, 8'h05));
    emit(8'h01, ins(T_LDI, 8'h40,  8'd0, 8'h05));
    emit(8'h02, ins(T_BEQ, 8'd0,   8'd1, 8'h40));
    rom[8'h03] = ins(T_LDI, 8'd9, 8'd0, 8'hEE);
    emit(8'h40, ins(T_LDI, 8'd3,   8'd0, 8'h33));
    emit(8'h41, ins(T_BNE, 8'd0,   8'd1, 8'h40));
    emit(8'h42, ins(T_LDI, 8'h60,  8'd0, 8'h80));
    emit(8'h43, ins(T_BLT, 8'd0,   8'd1, 8'h60));
    rom[8'h44] = ins(T_LDI, 8'd9, 8'd0, 8'hEE);
    emit(8'h60, ins(T_BEQ, 8'd0,   8'd1, 8'h70));
    emit(8'h61, ins(T_BNE, 8'd0,   8'd1, 8'h70));
    emit(8'h70, ins(T_UND, 8'd9,   8'd1, 8'h01));
    emit(8'h71, ins(T_BLT, 8'd0,   8'h60, 8'h01));
    emit(8'h72, ins(T_JMP, 8'd0,   8'd0, 8'h90));
    emit(8'h90, ins(T_HLT, 8'd0,   8'd0, 8'd0));
    exp_w(8'd1, 8'h05); exp_w(8'h40, 8'h05); exp_w(8'd3, 8'h33); exp_w(8'h60, 8'h80);
    pulse_start();
    wait_done(100);
    check("t3_icount", {16'd0, bus.icount}, 32'd13);
    check("t3_r9_untouched", {24'd0, regs[9]}, 32'd0);
    queues_empty("t3");

    // pc wraps 0xFF -> 0x00; second pass takes the BEQ out of the loop.
    clear_mem();
    emit(8'h00, ins(T_LDI,  8'h10, 8'd0, 8'h02));
    emit(8'h01, ins(T_ADDI, 8'd7,  8'd7, 8'h01));
    emit(8'h02, ins(T_BEQ,  8'd0,  8'd7, 8'h10));
    emit(8'h03, ins(T_JMP,  8'd0,  8'd0, 8'hFF));
    emit(8'hFF, ins(T_NOP,  8'd0,  8'd0, 8'd0));
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01); exp_fetch.push_back(8'h02);
    emit(8'h10, ins(T_HLT,  8'd0,  8'd0, 8'd0));
    exp_w(8'h10, 8'h02); exp_w(8'd7, 8'h01); exp_w(8'h10, 8'h02); exp_w(8'd7, 8'h02);
    pulse_start();
    wait_done(100);
    check("t4_icount", {16'd0, bus.icount}, 32'd9);
    queues_empty("t4");

    // start while busy is ignored; start in HALTED restarts with icount cleared.
    clear_mem();
    emit(8'h00, ins(T_LDI, 8'd1, 8'd0, 8'h11));
    emit(8'h01, ins(T_LDI, 8'd2, 8'd0, 8'h22));
    emit(8'h02, ins(T_HLT, 8'd0, 8'd0, 8'd0));
    exp_w(8'd1, 8'h11); exp_w(8'd2, 8'h22);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(100);
    check("t5_icount_a", {16'd0, bus.icount}, 32'd3);
    queues_empty("t5a");
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01); exp_fetch.push_back(8'h02);
    exp_w(8'd1, 8'h11); exp_w(8'd2, 8'h22);
    pulse_start();
    check("t5_icount_clr", {16'd0, bus.icount}, 32'd0);
    check("t5_done_clr", {31'd0, bus.done}, 32'd0);
    check("t5_restart_addr", {24'd0, bus.imem_addr}, 32'h00);
    wait_done(100);
    check("t5_icount_b", {16'd0, bus.icount}, 32'd3);
    queues_empty("t5b");

    // rst during EXEC of ADD suppresses the write and returns to reset state.
    clear_mem();
    emit(8'h00, ins(T_LDI, 8'd1, 8'd0, 8'h03));
    emit(8'h01, ins(T_LDI, 8'd2, 8'd0, 8'h04));
    emit(8'h02, ins(T_ADD, 8'd3, 8'd1, 8'd2));
    rom[8'h03] = ins(T_HLT, 8'd0, 8'd0, 8'd0);
    exp_w(8'd1, 8'h03); exp_w(8'd2, 8'h04);
    pulse_start();
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_we_in_rst", {31'd0, bus.we}, 32'd0);
    check("t6_data_in_rst", {24'd0, bus.data}, 32'd0);
    @(negedge clk);
    check("t6_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_done", {31'd0, bus.done}, 32'd0);
    check("t6_icount", {16'd0, bus.icount}, 32'd0);
    check("t6_addr", {24'd0, bus.imem_addr}, 32'h00);
    check("t6_ir", {8'd0, bus.dst, bus.src0, bus.src1}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_r3_unwritten", {24'd0, regs[3]}, 32'd0);
    check("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
    queues_empty("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
